// File: rtl/triangle_bounding_box_scanner.sv
// Triangle bounding-box scanner: latches three screen-space vertices, computes the
// clamped integer bounding box and streams every pixel in it in row-major order.

package triangle_bounding_box_scanner_pkg;

    // Homogeneous vertex, each component FixedPoint Q16.16 signed.
    typedef struct packed {
        logic signed [31:0] x;
        logic signed [31:0] y;
        logic signed [31:0] z;
        logic signed [31:0] w;
    } Vector4_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

endpackage

// Handshake: a pixel transfers on any rising edge where o_valid & i_ready are both 1;
// while o_valid is high and i_ready is low, o_x/o_y/o_v* hold, and o_valid never
// drops without a transfer except on reset.
module triangle_bounding_box_scanner
    import triangle_bounding_box_scanner_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  Vector4_t           i_v1,
    input  Vector4_t           i_v2,
    input  Vector4_t           i_v3,
    input  logic               i_ready,
    output logic signed [31:0] o_x,
    output logic signed [31:0] o_y,
    output logic               o_valid,
    output Vector4_t           o_v1,
    output Vector4_t           o_v2,
    output Vector4_t           o_v3,
    output logic               o_busy,
    output logic               o_done,
    output logic [1:0]         o_state
);

    localparam logic signed [31:0] X_LIMIT = SCREEN_WIDTH - 1;
    localparam logic signed [31:0] Y_LIMIT = SCREEN_HEIGHT - 1;

    function automatic logic signed [31:0] min3(input logic signed [31:0] a,
                                                input logic signed [31:0] b,
                                                input logic signed [31:0] c);
        logic signed [31:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic signed [31:0] max3(input logic signed [31:0] a,
                                                input logic signed [31:0] b,
                                                input logic signed [31:0] c);
        logic signed [31:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    scan_state_t        state_q, state_d;
    Vector4_t           v1_q, v1_d;
    Vector4_t           v2_q, v2_d;
    Vector4_t           v3_q, v3_d;
    logic signed [31:0] x_q, x_d;
    logic signed [31:0] y_q, y_d;
    logic signed [31:0] min_x_q, min_x_d;
    logic signed [31:0] max_x_q, max_x_d;
    logic signed [31:0] min_y_q, min_y_d;
    logic signed [31:0] max_y_q, max_y_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic signed [31:0] floor_min_x, floor_max_x, floor_min_y, floor_max_y;
    logic signed [31:0] box_min_x, box_max_x, box_min_y, box_max_y;
    logic               box_empty;
    logic               handshake;

    // Floor of the min/max equals min/max of the floors, so shift after selecting.
    always_comb begin
        floor_min_x = min3(v1_q.x, v2_q.x, v3_q.x) >>> 16;
        floor_max_x = max3(v1_q.x, v2_q.x, v3_q.x) >>> 16;
        floor_min_y = min3(v1_q.y, v2_q.y, v3_q.y) >>> 16;
        floor_max_y = max3(v1_q.y, v2_q.y, v3_q.y) >>> 16;

        box_min_x = (floor_min_x < 32'sd0)   ? 32'sd0  : floor_min_x;
        box_max_x = (floor_max_x > X_LIMIT)  ? X_LIMIT : floor_max_x;
        box_min_y = (floor_min_y < 32'sd0)   ? 32'sd0  : floor_min_y;
        box_max_y = (floor_max_y > Y_LIMIT)  ? Y_LIMIT : floor_max_y;

        box_empty = (box_min_x > box_max_x) || (box_min_y > box_max_y);
    end

    assign handshake = valid_q & i_ready;

    always_comb begin
        state_d = state_q;
        v1_d    = v1_q;
        v2_d    = v2_q;
        v3_d    = v3_q;
        x_d     = x_q;
        y_d     = y_q;
        min_x_d = min_x_q;
        max_x_d = max_x_q;
        min_y_d = min_y_q;
        max_y_d = max_y_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    v1_d    = i_v1;
                    v2_d    = i_v2;
                    v3_d    = i_v3;
                    busy_d  = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                min_x_d = box_min_x;
                max_x_d = box_max_x;
                min_y_d = box_min_y;
                max_y_d = box_max_y;
                if (box_empty) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    x_d     = box_min_x;
                    y_d     = box_min_y;
                    valid_d = 1'b1;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (handshake) begin
                    if (x_q == max_x_q) begin
                        if (y_q == max_y_q) begin
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            x_d = min_x_q;
                            y_d = y_q + 32'sd1;
                        end
                    end else begin
                        x_d = x_q + 32'sd1;
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            v1_q    <= '0;
            v2_q    <= '0;
            v3_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            min_x_q <= '0;
            max_x_q <= '0;
            min_y_q <= '0;
            max_y_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            x_q     <= x_d;
            y_q     <= y_d;
            min_x_q <= min_x_d;
            max_x_q <= max_x_d;
            min_y_q <= min_y_d;
            max_y_q <= max_y_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_x     = x_q;
    assign o_y     = y_q;
    assign o_valid = valid_q;
    assign o_v1    = v1_q;
    assign o_v2    = v2_q;
    assign o_v3    = v3_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_state = state_q;

endmodule

// File: doc/triangle_bounding_box_scanner.md
TRIANGLE_BOUNDING_BOX_SCANNER -- requirements
Module: triangle_bounding_box_scanner

Interface
REQ-001 Parameter SCREEN_WIDTH, default 640, horizontal pixel count; valid x range 0..SCREEN_WIDTH-1.
REQ-002 Parameter SCREEN_HEIGHT, default 480, vertical pixel count; valid y range 0..SCREEN_HEIGHT-1.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset: i_clk  input  1  rising-edge clock, the only clock.
REQ-004 i_reset  input  1  synchronous active-high reset.
REQ-005 i_start  input  1  one-cycle request to scan a triangle; sampled only in IDLE.
REQ-006 i_v1, i_v2, i_v3  input  Vector4_t each  screen-space vertices; only .x and .y are used, FixedPoint Q16.16 signed.
REQ-007 i_ready  input  1  downstream pixel stage accepts the current pixel.
REQ-008 o_x, o_y  output  32 signed each  integer pixel coordinate of the current candidate pixel.
REQ-009 o_valid  output  1  o_x/o_y/o_v* hold a valid candidate pixel.
REQ-010 o_v1, o_v2, o_v3  output  Vector4_t each  latched copies of the vertices, stable for the whole scan.
REQ-011 o_busy  output  1  high from the cycle after an accepted start until DONE is left.
REQ-012 o_done  output  1  single-cycle pulse when the scan completes.

Function
REQ-013 The FSM SHALL have states IDLE, SETUP, SCAN and DONE.
REQ-014 IDLE: i_start=1 -> latch i_v1..i_v3 into o_v1..o_v3 and go to SETUP; i_start while not IDLE is ignored.
REQ-015 SETUP, one cycle: compute the bounding box min_x/max_x/min_y/max_y over the three vertices.
REQ-016 Integer conversion SHALL be floor (arithmetic shift right by 16) applied to each min and max; e.g. 1.5 -> 1, -0.25 -> -1.
REQ-017 Clamping SHALL apply min_x,min_y >= 0, max_x <= SCREEN_WIDTH-1 and max_y <= SCREEN_HEIGHT-1.
REQ-018 Empty box (min_x>max_x or min_y>max_y after clamping): SETUP -> DONE with no o_valid beat.
REQ-019 Non-empty box: SETUP -> SCAN with o_x=min_x, o_y=min_y, o_valid=1; the first o_valid is 2 cycles after the i_start cycle.
REQ-020 The scan order SHALL be row-major: x increments; at x==max_x, x wraps to min_x and y increments.
REQ-021 Advance SHALL occur only on a handshake (o_valid & i_ready); while o_valid & !i_ready, o_x, o_y and o_v* SHALL hold stable.
REQ-022 Every pixel in the box SHALL be presented exactly once, with no skips or duplicates under any i_ready pattern.
REQ-023 A handshake at x==max_x and y==max_y SHALL send SCAN -> DONE and drop o_valid on the next cycle.
REQ-024 DONE SHALL last one cycle with o_done=1 and o_busy=1, then go to IDLE with o_busy=0.
REQ-025 An i_start in the DONE cycle is ignored; a new start is accepted only in IDLE.
REQ-026 Bounding box arithmetic SHALL be signed 32-bit and the x/y counters signed 32-bit; no overflow is possible for clamped screen sizes.
REQ-027 o_valid SHALL be high only in SCAN, and outputs SHALL be registered with no combinational path from i_ready to o_valid.

Reset
REQ-028 While i_reset=1 at a clock edge: state=IDLE, o_valid=0, o_busy=0, o_done=0, o_x=0, o_y=0, o_v1..o_v3=0.
REQ-029 A reset mid-scan SHALL abandon the scan immediately; o_valid=0 from the cycle after the reset edge, and no o_done is issued.
REQ-030 i_start asserted together with i_reset SHALL be ignored.

Verification
REQ-031 Basic scan, vertices (0,0),(3,0),(0,2), i_ready=1 -> 12 beats (0,0),(1,0),(2,0),(3,0),(0,1)..(3,2) in order; first o_valid at start+2; o_done one cycle after the last beat.
REQ-032 Backpressure, same triangle with i_ready=0 for 3 cycles while (2,1) is presented -> (2,1) held 4 cycles, then (3,1); total beats 12 with no duplicates.
REQ-033 Clamping, vertices (-5,-5),(2,-5),(-5,1.75) -> box x 0..2, y 0..1; 6 beats; fractional 1.75 floors to 1.
REQ-034 Offscreen, all vertices with x >= 700.0 -> zero o_valid beats; o_done at start+2; o_busy=0 at start+3.
REQ-035 Reset mid-scan, reset after the 5th handshake of REQ-031 -> o_valid=0 and o_busy=0 the next cycle, no o_done; a following start rescans all 12 pixels from (0,0).
REQ-036 Start while busy, i_start pulsed during SCAN with different vertices -> ignored; o_v* unchanged and the beat sequence unaffected.
